full_adder_bist: RTL and testbench

Synthesizable built-in self-test driver/checker for the single-bit `full_adder`: it sits on the opposite side of the adder's port list, driving `a`/`b`/`carryIn` and sampling `sum`/`carryOut`. On a start request it applies all eight input vectors in ascending order and holds each for a programmable settle time. It compares the adder outputs against the expected truth table and reports pass/fail, an error count and the first failing vector. It is used for power-on and field self-test of adder instances, with no simulation-only constructs.

---
 rtl/full_adder_bist_if.sv | 28 ++
 rtl/full_adder_bist.sv | 109 ++++++++++
 tb/tb_full_adder_bist.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/full_adder_bist_if.sv
// Connection bundle between the BIST controller and the adder it exercises.
// The master side is the BIST: it drives the adder inputs and the status outputs.
interface full_adder_bist_if;
  logic       start;
  logic       a;
  logic       b;
  logic       carryIn;
  logic       sum;
  logic       carryOut;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] errorCount;
  logic       firstFailValid;
  logic [2:0] firstFailVector;

  modport master (
    input  start, sum, carryOut,
    output a, b, carryIn, busy, done, pass,
           errorCount, firstFailValid, firstFailVector
  );

  modport slave (
    output start, sum, carryOut,
    input  a, b, carryIn, busy, done, pass,
           errorCount, firstFailValid, firstFailVector
  );
endinterface

// File: rtl/full_adder_bist.sv
// Built-in self-test for a single-bit full adder: steps all eight input
// vectors, holds each SETTLE_CYCLES+1 cycles, checks the response against the
// truth table, and keeps an error count and the first failing vector.
//
//   state | meaning
//   IDLE  | after reset, adder inputs parked at 000, waiting for start
//   RUN   | applying vector v, settle timer counting down to the sample cycle
//   DONE  | results held, inputs parked at 000, start launches a fresh run
module full_adder_bist #(
  parameter int SETTLE_CYCLES = 3
) (
  input logic               clk,
  input logic               reset,
  full_adder_bist_if.master bus
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_next;
  logic [2:0] v, v_next;
  logic [3:0] settle_cnt, settle_next;
  logic [3:0] err_cnt, err_next;
  logic       ff_valid, ff_valid_next;
  logic [2:0] ff_vec, ff_vec_next;

  logic exp_sum, exp_carry, mismatch, settle_tc;

  assign exp_sum   = v[2] ^ v[1] ^ v[0];
  assign exp_carry = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
  assign mismatch  = (bus.sum != exp_sum) || (bus.carryOut != exp_carry);
  assign settle_tc = (settle_cnt == 4'd0);

  // Next-state and datapath updates; everything holds unless a branch says otherwise.
  always_comb begin
    state_next    = state;
    v_next        = v;
    settle_next   = settle_cnt;
    err_next      = err_cnt;
    ff_valid_next = ff_valid;
    ff_vec_next   = ff_vec;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_next    = RUN;
          v_next        = 3'd0;
          settle_next   = SETTLE_LOAD;
          err_next      = 4'd0;
          ff_valid_next = 1'b0;
          ff_vec_next   = 3'd0;
        end
      end
      RUN: begin
        if (!settle_tc) begin
          settle_next = settle_cnt - 4'd1;
        end else begin
          if (mismatch) begin
            err_next = err_cnt + 4'd1;
            if (!ff_valid) begin
              ff_valid_next = 1'b1;
              ff_vec_next   = v;
            end
          end
          if (v == 3'd7) begin
            // v returns to 0 so the adder inputs are parked while DONE
            state_next = DONE;
            v_next     = 3'd0;
          end else begin
            v_next      = v + 3'd1;
            settle_next = SETTLE_LOAD;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      v          <= 3'd0;
      settle_cnt <= 4'd0;
      err_cnt    <= 4'd0;
      ff_valid   <= 1'b0;
      ff_vec     <= 3'd0;
    end else begin
      state      <= state_next;
      v          <= v_next;
      settle_cnt <= settle_next;
      err_cnt    <= err_next;
      ff_valid   <= ff_valid_next;
      ff_vec     <= ff_vec_next;
    end
  end

  // Adder inputs come straight from the vector register, so they never glitch.
  assign bus.a               = v[2];
  assign bus.b               = v[1];
  assign bus.carryIn         = v[0];
  assign bus.busy            = (state == RUN);
  assign bus.done            = (state == DONE);
  assign bus.pass            = (state == DONE) && (err_cnt == 4'd0);
  assign bus.errorCount      = err_cnt;
  assign bus.firstFailValid  = ff_valid;
  assign bus.firstFailVector = ff_vec;

endmodule

// File: tb/tb_full_adder_bist.sv
// Directed bench for full_adder_bist: two instances (settle 3 and settle 0),
// each looking at a behavioural adder with a selectable fault.
module tb_full_adder_bist;

  logic clk = 1'b0;
  logic reset;
  int   mode;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  full_adder_bist_if if3 ();
  full_adder_bist_if if0 ();

  full_adder_bist #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));
  full_adder_bist #(.SETTLE_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));

  // mode 0 ideal, 1 sum stuck at 0, 2 carryOut inverted, 3 sum wrong only on 110
  function automatic logic [1:0] adder_model(input int m, input logic [2:0] x);
    logic s, c;
    s = x[2] ^ x[1] ^ x[0];
    c = (x[2] & x[1]) | (x[2] & x[0]) | (x[1] & x[0]);
    case (m)
      1: s = 1'b0;
      2: c = ~c;
      3: if (x == 3'b110) s = ~s;
      default: ;
    endcase
    return {s, c};
  endfunction

  assign {if3.sum, if3.carryOut} = adder_model(mode, {if3.a, if3.b, if3.carryIn});
  assign {if0.sum, if0.carryOut} = adder_model(mode, {if0.a, if0.b, if0.carryIn});

  task automatic chk_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_idle3(input string tag);
    chk_val({tag, "_abc"},  8'({if3.a, if3.b, if3.carryIn}), 8'd0);
    chk_val({tag, "_busy"}, 8'(if3.busy), 8'd0);
    chk_val({tag, "_done"}, 8'(if3.done), 8'd0);
    chk_val({tag, "_pass"}, 8'(if3.pass), 8'd0);
    chk_val({tag, "_err"},  8'(if3.errorCount), 8'd0);
    chk_val({tag, "_ffv"},  8'(if3.firstFailValid), 8'd0);
    chk_val({tag, "_ffvec"}, 8'(if3.firstFailVector), 8'd0);
  endtask

  initial begin
    reset     = 1'b1;
    mode      = 0;
    if3.start = 1'b0;
    if0.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_idle3("rst");
    chk_val("rst0_done", 8'(if0.done), 8'd0);

    // ideal adder, settle 3: 4 cycles per vector, done after edge 32
    @(negedge clk); if3.start = 1'b1;
    @(negedge clk); if3.start = 1'b0;
    chk_val("t1_busy", 8'(if3.busy), 8'd1);
    chk_val("t1_done", 8'(if3.done), 8'd0);
    for (int e = 0; e < 32; e++) begin
      if (e > 0) @(negedge clk);
      chk_val("t1_vec", 8'({if3.a, if3.b, if3.carryIn}), 8'(e / 4));
    end
    chk_val("t1_done_e31", 8'(if3.done), 8'd0);
    @(negedge clk);
    chk_val("t1_done", 8'(if3.done), 8'd1);
    chk_val("t1_busy_end", 8'(if3.busy), 8'd0);
    chk_val("t1_pass", 8'(if3.pass), 8'd1);
    chk_val("t1_err", 8'(if3.errorCount), 8'd0);
    chk_val("t1_ffv", 8'(if3.firstFailValid), 8'd0);
    chk_val("t1_abc_end", 8'({if3.a, if3.b, if3.carryIn}), 8'd0);

    // sum stuck at 0: vectors 001,010,100,111 fail
    mode = 1;
    if3.start = 1'b1;
    @(negedge clk); if3.start = 1'b0;
    repeat (32) @(negedge clk);
    chk_val("t2_done", 8'(if3.done), 8'd1);
    chk_val("t2_err", 8'(if3.errorCount), 8'd4);
    chk_val("t2_ffvec", 8'(if3.firstFailVector), 8'd1);
    chk_val("t2_ffv", 8'(if3.firstFailValid), 8'd1);
    chk_val("t2_pass", 8'(if3.pass), 8'd0);

    // carryOut inverted: every vector fails, first fail visible after edge 4
    mode = 2;
    if3.start = 1'b1;
    @(negedge clk); if3.start = 1'b0;
    chk_val("t3_err_clr", 8'(if3.errorCount), 8'd0);
    chk_val("t3_done", 8'(if3.done), 8'd0);
    chk_val("t3_busy", 8'(if3.busy), 8'd1);
    repeat (3) @(negedge clk);
    chk_val("t3_ffv_e3", 8'(if3.firstFailValid), 8'd0);
    @(negedge clk);
    chk_val("t3_ffv_e4", 8'(if3.firstFailValid), 8'd1);
    chk_val("t3_ffvec_e4", 8'(if3.firstFailVector), 8'd0);
    chk_val("t3_err_e4", 8'(if3.errorCount), 8'd1);
    repeat (28) @(negedge clk);
    chk_val("t3_err", 8'(if3.errorCount), 8'd8);
    chk_val("t3_done_end", 8'(if3.done), 8'd1);
    chk_val("t3_pass", 8'(if3.pass), 8'd0);

    // reset while vector 011 is driven, then a clean run
    if3.start = 1'b1;
    @(negedge clk); if3.start = 1'b0;
    repeat (13) @(negedge clk);
    chk_val("t4_vec", 8'({if3.a, if3.b, if3.carryIn}), 8'd3);
    chk_val("t4_err_pre", 8'(if3.errorCount), 8'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle3("t4_rst");
    mode = 0;
    if3.start = 1'b1;
    @(negedge clk); if3.start = 1'b0;
    repeat (32) @(negedge clk);
    chk_val("t4_pass", 8'(if3.pass), 8'd1);
    chk_val("t4_err", 8'(if3.errorCount), 8'd0);
    chk_val("t4_ffv", 8'(if3.firstFailValid), 8'd0);

    // start held high: no restart while busy, immediate restart from DONE
    mode = 1;
    if3.start = 1'b1;
    @(negedge clk);
    repeat (32) @(negedge clk);
    chk_val("t5_done", 8'(if3.done), 8'd1);
    chk_val("t5_busy", 8'(if3.busy), 8'd0);
    chk_val("t5_err", 8'(if3.errorCount), 8'd4);
    chk_val("t5_ffvec", 8'(if3.firstFailVector), 8'd1);
    @(negedge clk);
    chk_val("t5_rs_busy", 8'(if3.busy), 8'd1);
    chk_val("t5_rs_done", 8'(if3.done), 8'd0);
    chk_val("t5_rs_err", 8'(if3.errorCount), 8'd0);
    chk_val("t5_rs_ffv", 8'(if3.firstFailValid), 8'd0);
    if3.start = 1'b0;
    mode = 0;
    repeat (32) @(negedge clk);
    chk_val("t5_pass", 8'(if3.pass), 8'd1);
    chk_val("t5_err_end", 8'(if3.errorCount), 8'd0);

    // settle 0: one cycle per vector, single fault on 110
    mode = 3;
    if0.start = 1'b1;
    @(negedge clk); if0.start = 1'b0;
    for (int e = 0; e < 8; e++) begin
      if (e > 0) @(negedge clk);
      chk_val("t6_vec", 8'({if0.a, if0.b, if0.carryIn}), 8'(e));
    end
    chk_val("t6_busy", 8'(if0.busy), 8'd1);
    chk_val("t6_done_e7", 8'(if0.done), 8'd0);
    @(negedge clk);
    chk_val("t6_done", 8'(if0.done), 8'd1);
    chk_val("t6_err", 8'(if0.errorCount), 8'd1);
    chk_val("t6_ffv", 8'(if0.firstFailValid), 8'd1);
    chk_val("t6_ffvec", 8'(if0.firstFailVector), 8'd6);
    chk_val("t6_pass", 8'(if0.pass), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
